// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared types and constants for the UART datapath blocks.
//   - tx_state_t       : transmit FSM encoding
//   - uart_frame_cfg_t : per-frame format fields, driven by the register map
//                        from its RW control register and latched by the
//                        transmitter at frame accept
//   - UART_DBITS_*     : encodings of the data-length field
package uart_pkg;

  localparam int UART_DIV_WIDTH = 16;

  localparam logic [1:0] UART_DBITS_5 = 2'd0;
  localparam logic [1:0] UART_DBITS_6 = 2'd1;
  localparam logic [1:0] UART_DBITS_7 = 2'd2;
  localparam logic [1:0] UART_DBITS_8 = 2'd3;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  typedef struct packed {
    logic [UART_DIV_WIDTH-1:0] div;
    logic [1:0]                dbits;
    logic                      par_en;
    logic                      par_odd;
    logic                      stop2;
  } uart_frame_cfg_t;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick
//   Loadable down-counter that marks bit-period boundaries. The counter is
//   loaded with the start value on i_start and then counts down to zero;
//   o_tick is high on the cycle the count is zero, which is the last cycle of
//   a bit period. On that cycle it reloads, so every period lasts reload+1
//   cycles. A reload value of 0 yields a tick every cycle.
//   Ports:
//     i_clk, i_rst   : clock, asynchronous active-high reset
//     i_start        : restart the period (frame accept)
//     i_start_val    : count loaded on i_start
//     i_run          : count enable; o_tick is suppressed when low
//     i_reload_val   : count reloaded at each period boundary
//     o_tick         : one-cycle strobe on the last cycle of each period
module uart_baud_tick #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [DIV_WIDTH-1:0] i_start_val,
  input  logic                 i_run,
  input  logic [DIV_WIDTH-1:0] i_reload_val,
  output logic                 o_tick
);

  logic [DIV_WIDTH-1:0] cnt;

  assign o_tick = i_run && (cnt == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= '0;
    end else if (i_start) begin
      cnt <= i_start_val;
    end else if (i_run) begin
      // Reload at zero instead of wrapping, so a bit never stretches.
      if (cnt == '0) cnt <= i_reload_val;
      else           cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//   UART transmit engine. Pops bytes from the TX FIFO over a valid/ready
//   handshake, latches the frame format at accept, and serializes
//   start / data (LSB first) / optional parity / 1-2 stop bits onto o_txd.
//   Ports:
//     i_clk, i_rst          : clock, asynchronous active-high reset
//     i_enable              : transmitter enable
//     i_cfg_div             : bit period minus one, in i_clk cycles
//     i_cfg_dbits           : data length code (5..8 bits)
//     i_cfg_par_en/_odd     : parity present / odd parity
//     i_cfg_stop2           : two stop bits
//     i_break               : hold the line low while idle
//     i_data, i_data_valid  : FIFO head byte and not-empty flag
//     o_data_ready          : FIFO pop strobe
//     o_txd                 : serial line, registered, idle high
//     o_busy                : frame in progress
//     o_done                : pulse on the last cycle of the final stop bit
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DIV_WIDTH  = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic [DIV_WIDTH-1:0]  i_cfg_div,
  input  logic [1:0]            i_cfg_dbits,
  input  logic                  i_cfg_par_en,
  input  logic                  i_cfg_par_odd,
  input  logic                  i_cfg_stop2,
  input  logic                  i_break,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_data_valid,
  output logic                  o_data_ready,
  output logic                  o_txd,
  output logic                  o_busy,
  output logic                  o_done
);

  // Even parity over the transmitted bits only, inverted for odd parity.
  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d,
                                       input logic [1:0]            dbits,
                                       input logic                  odd);
    logic [DATA_WIDTH-1:0] mask;
    case (dbits)
      UART_DBITS_5: mask = DATA_WIDTH'(8'h1F);
      UART_DBITS_6: mask = DATA_WIDTH'(8'h3F);
      UART_DBITS_7: mask = DATA_WIDTH'(8'h7F);
      UART_DBITS_8: mask = DATA_WIDTH'(8'hFF);
      default:      mask = '1;
    endcase
    return (^(d & mask)) ^ odd;
  endfunction

  tx_state_t             state;
  uart_frame_cfg_t       cfg_q;
  uart_frame_cfg_t       cfg_in;
  logic [DATA_WIDTH-1:0] data_q;
  logic [2:0]            bit_idx;
  logic [2:0]            next_idx;
  logic [2:0]            last_bit;
  logic                  stop_idx;
  logic                  stop_last;
  logic                  txd_q;
  logic                  tick;
  logic                  accept;
  logic                  busy;

  always_comb begin
    cfg_in         = '0;
    cfg_in.div     = UART_DIV_WIDTH'(i_cfg_div);
    cfg_in.dbits   = i_cfg_dbits;
    cfg_in.par_en  = i_cfg_par_en;
    cfg_in.par_odd = i_cfg_par_odd;
    cfg_in.stop2   = i_cfg_stop2;
  end

  // Ready depends only on registered state and the control inputs, never on
  // valid; reset is included so no pop can happen while it is held.
  assign o_data_ready = (state == TX_IDLE) && i_enable && !i_break && !i_rst;
  assign accept       = i_data_valid && o_data_ready;
  assign busy         = (state != TX_IDLE);

  assign next_idx  = bit_idx + 3'd1;
  assign last_bit  = {1'b0, cfg_q.dbits} + 3'd4;
  // stop_idx counts 0 then 1; the final stop bit is the one matching stop2.
  assign stop_last = (stop_idx == cfg_q.stop2);

  uart_baud_tick #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_baud_tick (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (accept),
    .i_start_val  (i_cfg_div),
    .i_run        (busy),
    .i_reload_val (DIV_WIDTH'(cfg_q.div)),
    .o_tick       (tick)
  );

  // Byte holding register: only meaningful after an accept, so no reset.
  always_ff @(posedge i_clk) begin
    if (accept) data_q <= i_data;
  end

  // Frame sequencing: the line value for the next bit is registered on the
  // tick that ends the current bit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= TX_IDLE;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      txd_q    <= 1'b1;
      cfg_q    <= '0;
    end else begin
      case (state)
        TX_IDLE: begin
          bit_idx  <= '0;
          stop_idx <= 1'b0;
          if (accept) begin
            state <= TX_START;
            txd_q <= 1'b0;
            cfg_q <= cfg_in;
          end else begin
            txd_q <= ~i_break;
          end
        end
        TX_START: begin
          if (tick) begin
            state <= TX_DATA;
            txd_q <= data_q[0];
          end
        end
        TX_DATA: begin
          if (tick) begin
            if (bit_idx == last_bit) begin
              if (cfg_q.par_en) begin
                state <= TX_PARITY;
                txd_q <= calc_parity(data_q, cfg_q.dbits, cfg_q.par_odd);
              end else begin
                state <= TX_STOP;
                txd_q <= 1'b1;
              end
            end else begin
              bit_idx <= next_idx;
              txd_q   <= data_q[next_idx];
            end
          end
        end
        TX_PARITY: begin
          if (tick) begin
            state <= TX_STOP;
            txd_q <= 1'b1;
          end
        end
        TX_STOP: begin
          if (tick) begin
            if (stop_last) state <= TX_IDLE;
            else           stop_idx <= 1'b1;
          end
        end
        default: begin
          state <= TX_IDLE;
          txd_q <= 1'b1;
        end
      endcase
    end
  end

  assign o_txd  = txd_q;
  assign o_busy = busy;
  assign o_done = (state == TX_STOP) && tick && stop_last;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer
//   Directed bench for uart_tx_serializer. Inputs change and outputs are
//   sampled on the falling edge; cycle c=1 is the first cycle after accept.
module tb_uart_tx_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] cfg_div;
  logic [1:0]  cfg_dbits;
  logic        cfg_par_en;
  logic        cfg_par_odd;
  logic        cfg_stop2;
  logic        brk;
  logic [7:0]  data;
  logic        data_valid;
  logic        data_ready;
  logic        txd;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_tx_serializer #(
    .DIV_WIDTH  (16),
    .DATA_WIDTH (8)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_enable      (enable),
    .i_cfg_div     (cfg_div),
    .i_cfg_dbits   (cfg_dbits),
    .i_cfg_par_en  (cfg_par_en),
    .i_cfg_par_odd (cfg_par_odd),
    .i_cfg_stop2   (cfg_stop2),
    .i_break       (brk),
    .i_data        (data),
    .i_data_valid  (data_valid),
    .o_data_ready  (data_ready),
    .o_txd         (txd),
    .o_busy        (busy),
    .o_done        (done)
  );

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; brk = 1'b0; data_valid = 1'b0; data = 8'h00;
    cfg_div = 16'd0; cfg_dbits = 2'd3; cfg_par_en = 1'b0; cfg_par_odd = 1'b0;
    cfg_stop2 = 1'b0;
    #1;
    n_vec++; if (txd !== 1'b1) begin n_err++; $display("FAIL reset_txd got %b exp 1", txd); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", done); end
    n_vec++; if (data_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b exp 0", data_ready); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (data_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready got %b exp 1", data_ready); end
    n_vec++; if (txd !== 1'b1) begin n_err++; $display("FAIL post_reset_txd got %b exp 1", txd); end
  endtask

  // One frame from idle; exp_seq bit i is the line value of bit period i.
  // chg_at > 0 rewrites div/dbits at that cycle to show they are ignored.
  task automatic test_frame(input string name, input logic [7:0] d,
                            input logic [15:0] div, input logic [1:0] dbits,
                            input logic pe, input logic po, input logic s2,
                            input logic [11:0] exp_seq, input int nbits,
                            input int chg_at, input logic [15:0] new_div,
                            input logic [1:0] new_dbits);
    int per;
    int total;
    logic exp_txd;
    @(negedge clk);
    data = d; cfg_div = div; cfg_dbits = dbits; cfg_par_en = pe;
    cfg_par_odd = po; cfg_stop2 = s2; data_valid = 1'b1;
    n_vec++; if (data_ready !== 1'b1) begin n_err++; $display("FAIL %s ready_pre got %b exp 1", name, data_ready); end
    @(posedge clk);
    per   = int'(div) + 1;
    total = nbits * per;
    for (int c = 1; c <= total; c++) begin
      @(negedge clk);
      if (c == 1) data_valid = 1'b0;
      if (c == chg_at) begin cfg_div = new_div; cfg_dbits = new_dbits; end
      exp_txd = exp_seq[(c - 1) / per];
      n_vec++; if (txd !== exp_txd) begin n_err++; $display("FAIL %s txd c=%0d got %b exp %b", name, c, txd, exp_txd); end
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL %s busy c=%0d got %b exp 1", name, c, busy); end
      n_vec++; if (done !== (c == total)) begin n_err++; $display("FAIL %s done c=%0d got %b exp %b", name, c, done, (c == total)); end
    end
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL %s busy_after got %b exp 0", name, busy); end
    n_vec++; if (txd !== 1'b1) begin n_err++; $display("FAIL %s txd_after got %b exp 1", name, txd); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL %s done_after got %b exp 0", name, done); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] seq1;
    logic [9:0] seq2;
    logic       exp_txd;
    int         ready_cnt;
    seq1 = 10'h34A;  // 0xA5 8N1
    seq2 = 10'h278;  // 0x3C 8N1
    ready_cnt = 0;
    @(negedge clk);
    data = 8'hA5; cfg_div = 16'd0; cfg_dbits = 2'd3; cfg_par_en = 1'b0;
    cfg_stop2 = 1'b0; data_valid = 1'b1;
    n_vec++; if (data_ready !== 1'b1) begin n_err++; $display("FAIL b2b ready_pre got %b exp 1", data_ready); end
    @(posedge clk);
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      if (c == 1) data = 8'h3C;
      if (c <= 10)      exp_txd = seq1[c - 1];
      else if (c == 11) exp_txd = 1'b1;
      else              exp_txd = seq2[c - 12];
      if (data_ready === 1'b1) ready_cnt++;
      n_vec++; if (txd !== exp_txd) begin n_err++; $display("FAIL b2b txd c=%0d got %b exp %b", c, txd, exp_txd); end
      n_vec++; if (busy !== (c != 11)) begin n_err++; $display("FAIL b2b busy c=%0d got %b exp %b", c, busy, (c != 11)); end
      n_vec++; if (done !== (c == 10 || c == 21)) begin n_err++; $display("FAIL b2b done c=%0d got %b exp %b", c, done, (c == 10 || c == 21)); end
      if (c == 11) begin
        n_vec++; if (data_ready !== 1'b1) begin n_err++; $display("FAIL b2b ready_gap got %b exp 1", data_ready); end
      end
      if (c == 12) data_valid = 1'b0;
    end
    n_vec++; if (ready_cnt != 1) begin n_err++; $display("FAIL b2b ready_count got %0d exp 1", ready_cnt); end
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b busy_after got %b exp 0", busy); end
  endtask

  task automatic test_enable_drop();
    @(negedge clk);
    data = 8'h0F; cfg_div = 16'd0; cfg_dbits = 2'd3; cfg_par_en = 1'b0;
    cfg_stop2 = 1'b0; data_valid = 1'b1; enable = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) enable = 1'b0;
      n_vec++; if (done !== (c == 10)) begin n_err++; $display("FAIL en_drop done c=%0d got %b exp %b", c, done, (c == 10)); end
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL en_drop busy got %b exp 0", busy); end
      n_vec++; if (data_ready !== 1'b0) begin n_err++; $display("FAIL en_drop ready got %b exp 0", data_ready); end
      n_vec++; if (txd !== 1'b1) begin n_err++; $display("FAIL en_drop txd got %b exp 1", txd); end
    end
    data_valid = 1'b0;
    enable = 1'b1;
  endtask

  task automatic test_reset_break();
    @(negedge clk);
    data = 8'h00; cfg_div = 16'd3; cfg_dbits = 2'd3; cfg_par_en = 1'b0;
    cfg_stop2 = 1'b0; data_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) data_valid = 1'b0;
    end
    n_vec++; if (txd !== 1'b0) begin n_err++; $display("FAIL rst_mid txd_data got %b exp 0", txd); end
    rst = 1'b1;
    #1;
    n_vec++; if (txd !== 1'b1) begin n_err++; $display("FAIL rst_mid txd got %b exp 1", txd); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid busy got %b exp 0", busy); end
    n_vec++; if (data_ready !== 1'b0) begin n_err++; $display("FAIL rst_mid ready got %b exp 0", data_ready); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++; if (data_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid idle_ready got %b exp 1", data_ready); end
    brk = 1'b1; data_valid = 1'b1; data = 8'h81; cfg_div = 16'd0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_vec++; if (txd !== 1'b0) begin n_err++; $display("FAIL break txd got %b exp 0", txd); end
      n_vec++; if (data_ready !== 1'b0) begin n_err++; $display("FAIL break ready got %b exp 0", data_ready); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL break busy got %b exp 0", busy); end
    end
    brk = 1'b0; data_valid = 1'b0;
    @(negedge clk);
    n_vec++; if (txd !== 1'b1) begin n_err++; $display("FAIL break_release txd got %b exp 1", txd); end
  endtask

  initial begin
    test_reset();
    test_frame("8N1_55", 8'h55, 16'd3, 2'd3, 1'b0, 1'b0, 1'b0, 12'h2AA, 10, 0, 16'd0, 2'd0);
    test_frame("7E2_C1", 8'hC1, 16'd0, 2'd2, 1'b1, 1'b0, 1'b1, 12'h682, 11, 0, 16'd0, 2'd0);
    test_frame("5O1_07", 8'h07, 16'd1, 2'd0, 1'b1, 1'b1, 1'b0, 12'h08E, 8, 0, 16'd0, 2'd0);
    test_back_to_back();
    test_frame("cfgchg_FF", 8'hFF, 16'd3, 2'd3, 1'b0, 1'b0, 1'b0, 12'h3FE, 10, 10, 16'd7, 2'd0);
    test_frame("cfgnew_FF", 8'hFF, 16'd7, 2'd0, 1'b0, 1'b0, 1'b0, 12'h07E, 7, 0, 16'd0, 2'd0);
    test_enable_drop();
    test_reset_break();
    test_frame("after_brk_81", 8'h81, 16'd0, 2'd3, 1'b0, 1'b0, 1'b0, 12'h302, 10, 0, 16'd0, 2'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
UART transmit engine. Sits downstream of the APB register map and the TX FIFO. Pops bytes from the FIFO over a valid/ready handshake and serializes them onto the TXD line. Frame format and bit period come from register-map configuration fields, which the block latches per frame. Reports busy/done status back toward the register map for status bits and interrupts.

Parameters:
DIV_WIDTH, 16, width of the bit-period divisor field.
DATA_WIDTH, 8, maximum data bits per frame; fixed at 8 for this design.

Ports:
i_clk  input  1  core clock.
i_rst  input  1  asynchronous, active-high reset.
i_enable  input  1  transmitter enable (control register bit).
i_cfg_div  input  DIV_WIDTH  bit period minus one, in i_clk cycles.
i_cfg_dbits  input  2  data length: 0=5, 1=6, 2=7, 3=8 bits.
i_cfg_par_en  input  1  parity bit present.
i_cfg_par_odd  input  1  1=odd parity, 0=even parity.
i_cfg_stop2  input  1  1=two stop bits, 0=one stop bit.
i_break  input  1  force break (line low) while idle.
i_data  input  8  byte from TX FIFO.
i_data_valid  input  1  FIFO not empty.
o_data_ready  output  1  pop strobe to FIFO (handshake ready).
o_txd  output  1  serial output; idle high.
o_busy  output  1  frame in progress.
o_done  output  1  one-cycle pulse at the end of each frame.

Behaviour:
- Reset (async, i_rst=1):
  - FSM goes to IDLE; o_txd=1, o_busy=0, o_done=0.
  - All counters and latched configuration clear.
  - o_data_ready=0 while i_rst is asserted.
- o_data_ready is derived from registered state: (state==IDLE) && i_enable && !i_break. There is no combinational path from i_data_valid.
- Accept: i_data_valid && o_data_ready at a rising edge. On the same edge the block latches i_data, i_cfg_div, i_cfg_dbits, i_cfg_par_en, i_cfg_par_odd and i_cfg_stop2. Configuration changes later in the frame are ignored.
- Latency: o_txd falls to 0 (start bit) in the cycle immediately after the accept edge.
- Bit period: every bit lasts exactly i_cfg_div+1 cycles, using the latched value. A divisor of 0 gives 1 cycle per bit and is legal. The bit counter is DIV_WIDTH wide and never wraps mid-bit.
- FSM states:
  - IDLE -> START on accept.
  - START -> DATA after one bit period.
  - DATA sends the LSB first, for dbits+5 bits.
  - DATA -> PARITY if par_en, else DATA -> STOP.
  - PARITY -> STOP after one bit period.
  - STOP lasts 1 or 2 bit periods, then the FSM returns to IDLE.
- Parity:
  - Even: XOR of the transmitted data bits only; bits above dbits+5 are excluded.
  - Odd: the inverse of the even value.
- o_busy is 1 from the cycle after accept through the last cycle of the final stop bit.
- o_done pulses for one cycle: the last cycle of the final stop bit.
- Back-to-back frames:
  - The FSM enters IDLE, so o_data_ready can assert, in the cycle after o_done.
  - If valid is already high, the next start bit begins 1 cycle after that accept.
  - Minimum idle gap between stop and start is therefore 1 cycle, with o_txd=1.
- i_enable deasserted mid-frame: the current frame completes normally, then no further accepts.
- i_break: while in IDLE, o_txd=0 and no accepts occur. If asserted mid-frame it is ignored until IDLE is reached. The line returns to 1 the cycle after i_break falls.
- Reset mid-frame: o_txd returns to 1 asynchronously. The in-flight byte is dropped; the FIFO has already popped it.
- o_txd is driven from a flop, so the line is glitch-free.

Decomposition:
- uart_pkg additions:
  - tx_state_t enum (IDLE, START, DATA, PARITY, STOP).
  - uart_frame_cfg_t struct {div, dbits, par_en, par_odd, stop2}.
  - Constants UART_DBITS_5..UART_DBITS_8.
  - The register map drives uart_frame_cfg_t fields from its RW control register.
- One sub-module is natural: uart_baud_tick.
  - Loadable down-counter of DIV_WIDTH bits.
  - Emits a one-cycle tick on the last cycle of each bit period.
  - Restarts on frame accept.
  - Reused later by the RX path.

Test Plan:
- 8N1, div=3, i_data=0x55 -> start at cycle 1 after accept. Each bit is 4 cycles. o_txd pattern is 0,1,0,1,0,1,0,1,0,1. Frame is 40 cycles. o_done pulses at cycle 40.
- 7E2, div=0, i_data=0xC1 -> data bits 1,0,0,0,0,0,1, then parity 0, then stop 1,1. Frame is 11 cycles. Bit 7 of the input is not sent.
- 5O1, div=1, i_data=0x07 -> data 1,1,1,0,0, parity 0 (three ones, odd). Frame is 8 bits, i.e. 16 cycles.
- Back-to-back: FIFO valid holds 0xA5 then 0x3C, 8N1, div=0 -> two frames separated by exactly 1 idle-high cycle. o_data_ready is high for exactly 1 cycle per byte.
- Mid-frame config change: change div 3->7 and dbits 8->5 during the DATA state of 0xFF -> the current frame stays 8 bits at 4 cycles/bit. The next frame uses the new values.
- Reset and break:
  - i_rst pulse during DATA -> o_txd=1 and o_busy=0 immediately, FSM in IDLE.
  - Then i_break=1 with valid=1 -> o_txd=0, o_data_ready=0.
  - Release break -> o_txd=1 next cycle, then accept.
